// File: rtl/ct_f_spsram_ctrl_8192x32.sv
// rtl/ct_f_spsram_ctrl_8192x32.sv - requester-side controller for an 8192x32 single-port SRAM
// Registered SRAM pins, valid/ready request port, in-order read response FIFO, init sweep.
module ct_f_spsram_ctrl_8192x32 #(
  parameter int          ADDR_WIDTH = 13,
  parameter int          RSP_DEPTH  = 4,
  parameter logic [31:0] INIT_VAL   = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [31:0]           rsp_rdata,
  input  logic                  init_start,
  output logic                  init_busy,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [31:0]           sram_wen,
  output logic [31:0]           sram_d,
  input  logic [31:0]           sram_q
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = $clog2(RSP_DEPTH + 3);

  typedef enum logic {ST_RUN, ST_INIT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  req_rdy_q, req_rdy_d;
  logic                  rd_p1_q, rd_p1_d;
  logic                  rd_p2_q, rd_p2_d;
  logic [31:0]           fifo_mem_q [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] sram_a_q, sram_a_d;
  logic                  sram_cen_q, sram_cen_d;
  logic                  sram_gwen_q, sram_gwen_d;
  logic [31:0]           sram_wen_q, sram_wen_d;
  logic [31:0]           sram_d_q, sram_d_d;
  logic [OW-1:0]         outstanding_d;
  logic                  accept;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept = req_vld && req_rdy_q;
  // rd_p2_q marks the cycle in which sram_q carries read data
  assign push   = rd_p2_q;
  assign pop    = (count_q != '0) && rsp_rdy;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = 1'b0;
    sram_a_d    = sram_a_q;
    sram_d_d    = sram_d_q;
    sram_cen_d  = 1'b1;
    sram_gwen_d = 1'b1;
    sram_wen_d  = '1;
    rd_p1_d     = accept && !req_wr;
    rd_p2_d     = rd_p1_q;

    if (state_q == ST_RUN) begin
      if (accept) begin
        sram_cen_d  = 1'b0;
        sram_a_d    = req_addr;
        sram_gwen_d = ~req_wr;
        sram_d_d    = req_wdata;
        for (int k = 0; k < 4; k++) begin
          sram_wen_d[8*k +: 8] = req_wr ? {8{~req_be[k]}} : 8'hFF;
        end
      end
      if (init_start) begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    end else begin
      sram_cen_d  = 1'b0;
      sram_gwen_d = 1'b0;
      sram_wen_d  = '0;
      sram_d_d    = INIT_VAL;
      sram_a_d    = init_cnt_q;
      init_cnt_d  = init_cnt_q + 1'b1;
      if (init_cnt_q == '1) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    // Ready is registered, so it is computed from next-cycle occupancy
    outstanding_d = OW'(count_d) + OW'(rd_p1_d) + OW'(rd_p2_d);
    req_rdy_d     = (state_d == ST_RUN) && (outstanding_d < OW'(RSP_DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      req_rdy_q   <= 1'b0;
      rd_p1_q     <= 1'b0;
      rd_p2_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sram_a_q    <= '0;
      sram_cen_q  <= 1'b1;
      sram_gwen_q <= 1'b1;
      sram_wen_q  <= '1;
      sram_d_q    <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      req_rdy_q   <= req_rdy_d;
      rd_p1_q     <= rd_p1_d;
      rd_p2_q     <= rd_p2_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sram_a_q    <= sram_a_d;
      sram_cen_q  <= sram_cen_d;
      sram_gwen_q <= sram_gwen_d;
      sram_wen_q  <= sram_wen_d;
      sram_d_q    <= sram_d_d;
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= sram_q;
      end
    end
  end

  assign req_rdy   = req_rdy_q;
  assign rsp_vld   = (count_q != '0);
  assign rsp_rdata = fifo_mem_q[rd_ptr_q];
  assign init_busy = (state_q == ST_INIT);
  assign init_done = init_done_q;
  assign sram_a    = sram_a_q;
  assign sram_cen  = sram_cen_q;
  assign sram_gwen = sram_gwen_q;
  assign sram_wen  = sram_wen_q;
  assign sram_d    = sram_d_q;

endmodule

// File: tb/tb_ct_f_spsram_ctrl_8192x32.sv
// tb/tb_ct_f_spsram_ctrl_8192x32.sv - directed bench for ct_f_spsram_ctrl_8192x32
// Includes a behavioural SRAM with registered Q and per-bit active-low write mask.
module tb_ct_f_spsram_ctrl_8192x32;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_vld, req_rdy, req_wr;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_vld, rsp_rdy;
  logic [31:0] rsp_rdata;
  logic        init_start, init_busy, init_done;
  logic [12:0] sram_a;
  logic        sram_cen, sram_gwen;
  logic [31:0] sram_wen, sram_d;
  logic [31:0] sram_q;
  logic [31:0] mem [0:8191];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  ct_f_spsram_ctrl_8192x32 #(
    .ADDR_WIDTH(13),
    .RSP_DEPTH (4),
    .INIT_VAL  (32'hA5A5_A5A5)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .init_start(init_start),
    .init_busy (init_busy),
    .init_done (init_done),
    .sram_a    (sram_a),
    .sram_cen  (sram_cen),
    .sram_gwen (sram_gwen),
    .sram_wen  (sram_wen),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  // SRAM model: write bits where WEN is 0, Q registered one cycle after a read
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= mem[sram_a];
    end
  end

  task automatic do_req(input logic wr, input logic [12:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    bit ok = 0;
    int n = 0;
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    while (!ok && n < 50) begin
      @(negedge CLK);
      if (req_rdy) ok = 1;
      @(posedge CLK); #1;
      n++;
    end
    req_vld = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL req_accept addr=%h: got not accepted, expected accepted within 50 cycles", addr);
    end
  endtask

  task automatic read_expect(input logic [12:0] addr, input logic [31:0] exp, input string name,
                             output int lat);
    bit got = 0;
    rsp_rdy = 1'b1;
    do_req(1'b0, addr, 32'h0, 4'h0);
    lat = 0;
    while (!got && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (rsp_vld) got = 1;
    end
    tests_run++;
    if (!got || rsp_rdata !== exp) begin
      tests_failed++;
      $display("FAIL %s: got vld=%0b data=%h, expected vld=1 data=%h", name, got, rsp_rdata, exp);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 32'hFFFF_FFFF ||
        sram_a !== 13'h0 || sram_d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_pins: got cen=%b gwen=%b wen=%h a=%h d=%h, expected 1 1 ffffffff 0000 00000000",
               sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
    end
    tests_run++;
    if (rsp_vld !== 1'b0 || rsp_rdata !== 32'h0 || init_busy !== 1'b0 || init_done !== 1'b0 ||
        req_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got vld=%b rdata=%h busy=%b done=%b rdy=%b, expected 0 0 0 0 0",
               rsp_vld, rsp_rdata, init_busy, init_done, req_rdy);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (req_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rdy_first: got %b expected 0", req_rdy);
    end
    @(negedge CLK);
    tests_run++;
    if (req_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_rdy_rise: got %b expected 1", req_rdy);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_write_read();
    int lat;
    do_req(1'b1, 13'h0005, 32'hDEAD_BEEF, 4'hF);
    @(negedge CLK);
    tests_run++;
    if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 32'h0 || sram_a !== 13'h0005 ||
        sram_d !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL wr_pins: got cen=%b gwen=%b wen=%h a=%h d=%h, expected 0 0 00000000 0005 deadbeef",
               sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
    end
    @(negedge CLK);
    tests_run++;
    if (sram_cen !== 1'b1 || sram_gwen !== 1'b1 || sram_wen !== 32'hFFFF_FFFF || sram_a !== 13'h0005) begin
      tests_failed++;
      $display("FAIL idle_pins: got cen=%b gwen=%b wen=%h a=%h, expected 1 1 ffffffff 0005",
               sram_cen, sram_gwen, sram_wen, sram_a);
    end
    @(posedge CLK); #1;
    read_expect(13'h0005, 32'hDEAD_BEEF, "rd_full_word", lat);
    tests_run++;
    if (lat != 3) begin
      tests_failed++;
      $display("FAIL rd_latency: got %0d expected 3", lat);
    end
  endtask

  task automatic test_partial_write();
    int lat;
    do_req(1'b1, 13'h0005, 32'h0000_AA00, 4'b0010);
    @(negedge CLK);
    tests_run++;
    if (sram_wen !== 32'hFFFF_00FF || sram_cen !== 1'b0 || sram_gwen !== 1'b0) begin
      tests_failed++;
      $display("FAIL be_mask: got wen=%h cen=%b gwen=%b, expected ffff00ff 0 0", sram_wen, sram_cen, sram_gwen);
    end
    @(posedge CLK); #1;
    read_expect(13'h0005, 32'hDEAD_AAEF, "rd_partial", lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    do_req(1'b1, 13'h1234, 32'hCAFE_F00D, 4'hF);
    read_expect(13'h1234, 32'hCAFE_F00D, "rd_after_wr", lat);
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    int stall_acc = -1;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) do_req(1'b1, 13'(16 + i), 32'h5100_0010 + 32'(i), 4'hF);
    rsp_rdy = 1'b0; req_wr = 1'b0; req_be = 4'h0; req_wdata = 32'h0;
    req_vld = 1'b1; req_addr = 13'h0010;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge CLK);
      if (rsp_vld && rsp_rdy) begin
        exp = 32'h5100_0010 + 32'(got);
        tests_run++;
        if (rsp_rdata !== exp) begin
          tests_failed++;
          $display("FAIL bp_order[%0d]: got %h expected %h", got, rsp_rdata, exp);
        end
        got++;
      end
      if (req_vld && req_rdy) acc++;
      @(posedge CLK); #1;
      if (cyc == 9) begin
        stall_acc = acc;
        rsp_rdy = 1'b1;
      end
      req_vld = (acc < 8);
      req_addr = 13'(16 + acc);
    end
    req_vld = 1'b0;
    tests_run++;
    if (stall_acc != 4) begin
      tests_failed++;
      $display("FAIL bp_cap: got %0d accepts while stalled, expected 4", stall_acc);
    end
    tests_run++;
    if (acc != 8 || got != 8) begin
      tests_failed++;
      $display("FAIL bp_total: got acc=%0d rsp=%0d, expected 8 8", acc, got);
    end
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    tests_run++;
    if (rsp_vld !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_extra_rsp: got rsp_vld=%b expected 0", rsp_vld);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_init();
    int busy_cnt = 0, wr_cnt = 0, seq_err = 0, rdy_err = 0, done_cnt = 0, done_busy = 0;
    int lat;
    rsp_rdy = 1'b1;
    init_start = 1'b1;
    @(posedge CLK); #1;
    init_start = 1'b0;
    for (int cyc = 0; cyc < 8205; cyc++) begin
      @(negedge CLK);
      if (init_busy) begin
        busy_cnt++;
        if (req_rdy) rdy_err++;
      end
      if (!sram_cen && !sram_gwen && sram_wen == 32'h0 && sram_d == 32'hA5A5_A5A5) begin
        if (int'(sram_a) != wr_cnt) seq_err++;
        wr_cnt++;
      end
      if (init_done) begin
        done_cnt++;
        if (init_busy) done_busy++;
      end
    end
    tests_run++;
    if (busy_cnt != 8192) begin
      tests_failed++;
      $display("FAIL init_busy_len: got %0d expected 8192", busy_cnt);
    end
    tests_run++;
    if (wr_cnt != 8192 || seq_err != 0) begin
      tests_failed++;
      $display("FAIL init_writes: got %0d writes %0d out of order, expected 8192 0", wr_cnt, seq_err);
    end
    tests_run++;
    if (rdy_err != 0) begin
      tests_failed++;
      $display("FAIL init_rdy: got %0d ready cycles during init, expected 0", rdy_err);
    end
    tests_run++;
    if (done_cnt != 1 || done_busy != 0) begin
      tests_failed++;
      $display("FAIL init_done: got %0d pulses (%0d while busy), expected 1 (0)", done_cnt, done_busy);
    end
    @(posedge CLK); #1;
    read_expect(13'h0000, 32'hA5A5_A5A5, "init_rd_first", lat);
    read_expect(13'h1FFF, 32'hA5A5_A5A5, "init_rd_last", lat);
  endtask

  task automatic test_reset_mid_init();
    bit found = 0;
    int bad = 0;
    rsp_rdy = 1'b0;
    do_req(1'b0, 13'h0020, 32'h0, 4'h0);
    do_req(1'b0, 13'h0021, 32'h0, 4'h0);
    init_start = 1'b1;
    @(posedge CLK); #1;
    init_start = 1'b0;
    for (int n = 0; n < 400 && !found; n++) begin
      @(negedge CLK);
      if (!sram_cen && sram_a == 13'h0100) found = 1;
    end
    tests_run++;
    if (!found || !rsp_vld || !init_busy) begin
      tests_failed++;
      $display("FAIL rst_setup: got found=%0b vld=%b busy=%b, expected 1 1 1", found, rsp_vld, init_busy);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (sram_cen !== 1'b1 || rsp_vld !== 1'b0 || init_busy !== 1'b0 || init_done !== 1'b0 ||
        req_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_abort: got cen=%b vld=%b busy=%b done=%b rdy=%b, expected 1 0 0 0 0",
               sram_cen, rsp_vld, init_busy, init_done, req_rdy);
    end
    @(negedge CLK);
    tests_run++;
    if (req_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_rdy_rise: got %b expected 1", req_rdy);
    end
    rsp_rdy = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      if (init_done || rsp_vld || !sram_cen || init_busy) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rst_quiet: got %0d cycles with activity after reset, expected 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    sram_q = 32'h0;
    RST = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = 13'h0; req_wdata = 32'h0;
    req_be = 4'h0; rsp_rdy = 1'b1; init_start = 1'b0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_back_to_back();
    test_backpressure();
    test_init();
    test_reset_mid_init();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
